// File: rtl/bus_reg_bank_pkg.sv
// Shared types and constants for the bus_reg_bank register slave.
package bus_reg_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK
  } state_e;

  localparam int          OFS_ID     = 0;
  localparam int          OFS_DIAG   = 1;
  localparam int          OFS_CTRL   = 2;
  localparam int          DROP_W     = 8;
  localparam logic [31:0] DEFAULT_ID = 32'h0B0B_0001;

endpackage

// File: rtl/bus_reg_bank_if.sv
// Request/response bus between the bridge (master) and the register bank (slave).
interface bus_reg_bank_if;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        wen_i;
  logic        ren_i;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        ack_o;

  modport master (output addr_i, wdata_i, wen_i, ren_i, input rdata_o, err_o, ack_o);
  modport slave  (input addr_i, wdata_i, wen_i, ren_i, output rdata_o, err_o, ack_o);
endinterface

// File: rtl/bus_reg_bank.sv
// Register bank slave: ID, DIAG, NREG control words, NSTAT status words, programmable ack latency.
// Define BUS_REG_BANK_STICKY_EN to make status words sticky with write-1-to-clear.
module bus_reg_bank
  import bus_reg_bank_pkg::*;
#(
  parameter int          NREG  = 4,
  parameter int          NSTAT = 4,
  parameter int          AW    = 20,
  parameter int          LAT   = 1,
  parameter logic [31:0] ID    = DEFAULT_ID
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  bus_reg_bank_if.slave       bus,
  output logic [NREG*32-1:0]  ctrl_o,
  output logic [NREG-1:0]     wr_stb_o,
  input  logic [NSTAT*32-1:0] stat_i
);

  localparam int WW = AW - 2;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

`ifdef BUS_REG_BANK_STICKY_EN
  localparam logic STAT_RO = 1'b0;
`else
  localparam logic STAT_RO = 1'b1;
`endif

  state_e            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [WW-1:0]     word;
  logic              req, accept, drop, enter_ack, do_wr;
  logic              hit_id, hit_diag, dec_err;
  logic [NREG-1:0]   ctrl_sel;
  logic [NSTAT-1:0]  stat_sel;
  logic [31:0]       dec_rdata;
  logic [31:0]       ctrl_q [NREG];
  logic [31:0]       stat_rd [NSTAT];
  logic [DROP_W-1:0] drop_cnt;
  logic              cap_err, ack_q, err_q;
  logic [31:0]       cap_rdata, rdata_q;
  logic [NREG-1:0]   wr_pend, wr_stb;
  logic              unused_addr_hi;

  assign word           = bus.addr_i[AW-1:2];
  assign unused_addr_hi = ^bus.addr_i[31:AW];
  assign req            = bus.wen_i | bus.ren_i;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    hit_id   = (word == WW'(OFS_ID));
    hit_diag = (word == WW'(OFS_DIAG));
    for (int k = 0; k < NREG; k++)  ctrl_sel[k] = (word == WW'(OFS_CTRL + k));
    for (int s = 0; s < NSTAT; s++) stat_sel[s] = (word == WW'(OFS_CTRL + NREG + s));

    dec_err = (bus.wen_i & bus.ren_i)
            | (bus.addr_i[1:0] != 2'b00)
            | ~(hit_id | hit_diag | (|ctrl_sel) | (|stat_sel))
            | (bus.wen_i & hit_id)
            | (bus.wen_i & STAT_RO & (|stat_sel));

    dec_rdata = '0;
    if (!dec_err && !bus.wen_i) begin
      if (hit_id)   dec_rdata = ID;
      if (hit_diag) dec_rdata = {{(32-DROP_W){1'b0}}, drop_cnt};
      for (int k = 0; k < NREG; k++)  if (ctrl_sel[k]) dec_rdata = dec_rdata | ctrl_q[k];
      for (int s = 0; s < NSTAT; s++) if (stat_sel[s]) dec_rdata = dec_rdata | stat_rd[s];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state)
      ST_IDLE: if (req) begin
        accept = 1'b1;
        if (LAT == 1) begin
          state_nx = ST_ACK;
        end else begin
          state_nx = ST_WAIT;
          cnt_nx   = CW'(LAT - 1);
        end
      end
      ST_WAIT: begin
        drop = req;
        if (cnt == CW'(1)) state_nx = ST_ACK;
        else               cnt_nx   = cnt - 1'b1;
      end
      ST_ACK: begin
        drop     = req;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
    enter_ack = (state_nx == ST_ACK);
    do_wr     = accept & bus.wen_i & ~dec_err;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cap_err   <= 1'b0;
      cap_rdata <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ack_q <= enter_ack;
      err_q <= 1'b0;
      if (accept) begin
        cap_err   <= dec_err;
        cap_rdata <= dec_rdata;
      end
      // With LAT=1 the ack is loaded straight from the decode in the request cycle.
      if (enter_ack) begin
        err_q   <= (state == ST_IDLE) ? dec_err   : cap_err;
        rdata_q <= (state == ST_IDLE) ? dec_rdata : cap_rdata;
      end
    end
  end

  // NOTE: the control array is reset because its contents drive the fabric directly.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < NREG; k++) ctrl_q[k] <= '0;
      drop_cnt <= '0;
      wr_pend  <= '0;
      wr_stb   <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        if (do_wr && ctrl_sel[k]) ctrl_q[k] <= bus.wdata_i;
        wr_pend[k] <= do_wr & ctrl_sel[k];
      end
      wr_stb <= wr_pend;
      if (do_wr && hit_diag)              drop_cnt <= '0;
      else if (drop && (drop_cnt != '1))  drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef BUS_REG_BANK_STICKY_EN
  logic [31:0] stat_q [NSTAT];

  // A bit set on stat_i in the same cycle as a clear wins over the clear.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < NSTAT; s++) stat_q[s] <= '0;
    end else begin
      for (int s = 0; s < NSTAT; s++)
        stat_q[s] <= (stat_q[s] & ~((do_wr && stat_sel[s]) ? bus.wdata_i : 32'h0))
                   | stat_i[32*s +: 32];
    end
  end

  always_comb begin
    for (int s = 0; s < NSTAT; s++) stat_rd[s] = stat_q[s];
  end
`else
  always_comb begin
    for (int s = 0; s < NSTAT; s++) stat_rd[s] = stat_i[32*s +: 32];
  end
`endif

  for (genvar k = 0; k < NREG; k++) begin : g_ctrl
    assign ctrl_o[32*k +: 32] = ctrl_q[k];
  end

  assign wr_stb_o    = wr_stb;
  assign bus.ack_o   = ack_q;
  assign bus.err_o   = err_q;
  assign bus.rdata_o = rdata_q;

endmodule

// File: tb/tb_bus_reg_bank.sv
// Directed self-checking bench: a LAT=1 and a LAT=4 instance exercised with hand-computed vectors.
module tb_bus_reg_bank;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [127:0] ctrl1, ctrl4, stat1, stat4;
  logic [3:0]   stb1, stb4;
  int           n_checks = 0;
  int           n_pass = 0;

  always #5 clk = ~clk;

  bus_reg_bank_if b1 ();
  bus_reg_bank_if b4 ();

  bus_reg_bank #(.LAT(1)) u1 (
    .clk_i(clk), .rstn_i(rstn), .bus(b1), .ctrl_o(ctrl1), .wr_stb_o(stb1), .stat_i(stat1)
  );
  bus_reg_bank #(.LAT(4)) u4 (
    .clk_i(clk), .rstn_i(rstn), .bus(b4), .ctrl_o(ctrl4), .wr_stb_o(stb4), .stat_i(stat4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic we, input logic re,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel == 1) begin
      b1.wen_i = we; b1.ren_i = re; b1.addr_i = a; b1.wdata_i = d;
    end else begin
      b4.wen_i = we; b4.ren_i = re; b4.addr_i = a; b4.wdata_i = d;
    end
  endtask

  // One request; returns cycles from request to ack (-1 on timeout) and the acked response.
  task automatic xfer(input int sel, input logic we, input logic re,
                      input logic [31:0] a, input logic [31:0] d,
                      output int lat, output logic [31:0] rd, output logic er);
    logic ack;
    @(negedge clk);
    drive(sel, we, re, a, d);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    lat = 1;
    ack = (sel == 1) ? b1.ack_o : b4.ack_o;
    while (!ack && lat < 20) begin
      @(negedge clk);
      lat++;
      ack = (sel == 1) ? b1.ack_o : b4.ack_o;
    end
    if (!ack) lat = -1;
    rd = (sel == 1) ? b1.rdata_o : b4.rdata_o;
    er = (sel == 1) ? b1.err_o : b4.err_o;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    int          seen;

    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
    stat1 = {32'hCAFE_0003, 32'h0000_0011, 32'h0000_0022, 32'h0000_0000};
    stat4 = {96'h0, 32'h0000_0055};

    repeat (3) @(negedge clk);
    check("rst_ctrl", ctrl1[31:0], 32'h0);
    check("rst_ack", {31'h0, b1.ack_o}, 32'h0);
    check("rst_rdata", b4.rdata_o, 32'h0);
    check("rst_stb", {28'h0, stb1}, 32'h0);
    rstn = 1'b1;

    // LAT=1 write: ctrl updates and ack next cycle, strobe one cycle later
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 32'h08, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    check("wr_ack", {31'h0, b1.ack_o}, 32'h1);
    check("wr_err", {31'h0, b1.err_o}, 32'h0);
    check("wr_rdata", b1.rdata_o, 32'h0);
    check("wr_ctrl", ctrl1[31:0], 32'hDEAD_BEEF);
    check("wr_stb_early", {28'h0, stb1}, 32'h0);
    @(negedge clk);
    check("wr_stb", {28'h0, stb1}, 32'h1);
    check("wr_ack_gone", {31'h0, b1.ack_o}, 32'h0);
    @(negedge clk);
    check("wr_stb_end", {28'h0, stb1}, 32'h0);

    xfer(1, 1'b0, 1'b1, 32'h08, 32'h0, lat, rd, er);
    check("rd_ctrl_lat", 32'(lat), 32'd1);
    check("rd_ctrl", rd, 32'hDEAD_BEEF);
    xfer(1, 1'b1, 1'b0, 32'h14, 32'h1234_5678, lat, rd, er);
    check("wr_last_ctrl", ctrl1[127:96], 32'h1234_5678);
    xfer(1, 1'b0, 1'b1, 32'h00, 32'h0, lat, rd, er);
    check("rd_id", rd, 32'h0B0B_0001);
    xfer(1, 1'b0, 1'b1, 32'h03, 32'h0, lat, rd, er);
    check("misalign_err", {31'h0, er}, 32'h1);
    check("misalign_rdata", rd, 32'h0);
    xfer(1, 1'b1, 1'b0, 32'h00, 32'hFFFF_FFFF, lat, rd, er);
    check("wr_id_err", {31'h0, er}, 32'h1);
    xfer(1, 1'b0, 1'b1, 32'h00, 32'h0, lat, rd, er);
    check("id_unchanged", rd, 32'h0B0B_0001);
    xfer(1, 1'b0, 1'b1, 32'h24, 32'h0, lat, rd, er);
    check("rd_last_stat", rd, 32'hCAFE_0003);
    xfer(1, 1'b0, 1'b1, 32'h28, 32'h0, lat, rd, er);
    check("past_map_err", {31'h0, er}, 32'h1);
    xfer(1, 1'b1, 1'b1, 32'h08, 32'hAAAA_AAAA, lat, rd, er);
    check("wen_ren_err", {31'h0, er}, 32'h1);
    check("wen_ren_ctrl", ctrl1[31:0], 32'hDEAD_BEEF);
    check("wen_ren_stb", {28'h0, stb1}, 32'h0);

`ifdef BUS_REG_BANK_STICKY_EN
    @(negedge clk);
    stat1[3] = 1'b1;
    @(negedge clk);
    stat1[3] = 1'b0;
    xfer(1, 1'b0, 1'b1, 32'h18, 32'h0, lat, rd, er);
    check("sticky_rd", rd, 32'h0000_0008);
    xfer(1, 1'b1, 1'b0, 32'h18, 32'h0000_0008, lat, rd, er);
    check("sticky_w1c_err", {31'h0, er}, 32'h0);
    xfer(1, 1'b0, 1'b1, 32'h18, 32'h0, lat, rd, er);
    check("sticky_cleared", rd, 32'h0);
`else
    xfer(1, 1'b1, 1'b0, 32'h18, 32'h0000_0008, lat, rd, er);
    check("wr_stat_err", {31'h0, er}, 32'h1);
`endif

    // LAT=4 read with drops during WAIT and during the ACK cycle
    @(negedge clk);
    drive(4, 1'b0, 1'b1, 32'h18, 32'h0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 2 || n == 4) drive(4, 1'b0, 1'b1, 32'h00, 32'h0);
      else                  drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
      check($sformatf("lat4_ack_c%0d", n), {31'h0, b4.ack_o}, {31'h0, n == 4});
      if (n == 4) begin
        check("lat4_rdata", b4.rdata_o, 32'h55);
        check("lat4_err", {31'h0, b4.err_o}, 32'h0);
      end
    end
    xfer(4, 1'b0, 1'b1, 32'h04, 32'h0, lat, rd, er);
    check("diag_lat", 32'(lat), 32'd4);
    check("diag_drops", rd, 32'h2);
    xfer(4, 1'b1, 1'b0, 32'h04, 32'h0, lat, rd, er);
    check("diag_wr_err", {31'h0, er}, 32'h0);
    xfer(4, 1'b0, 1'b1, 32'h04, 32'h0, lat, rd, er);
    check("diag_cleared", rd, 32'h0);
    xfer(4, 1'b0, 1'b1, 32'h00, 32'h0, lat, rd, er);
    check("lat4_id", rd, 32'h0B0B_0001);

    // Reset in WAIT: no ack, outputs cleared, next request served normally
    @(negedge clk);
    drive(4, 1'b0, 1'b1, 32'h18, 32'h0);
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    rstn = 1'b0;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (b4.ack_o) seen++;
    end
    check("rst_mid_noack", 32'(seen), 32'd0);
    check("rst_mid_rdata", b4.rdata_o, 32'h0);
    check("rst_mid_ctrl", ctrl1[127:96], 32'h0);
    rstn = 1'b1;
    xfer(4, 1'b0, 1'b1, 32'h00, 32'h0, lat, rd, er);
    check("post_rst_lat", 32'(lat), 32'd4);
    check("post_rst_id", rd, 32'h0B0B_0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
